fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage directly upstream of decode/control. Holds the PC, issues single-outstanding requests to instruction memory over a valid/ready handshake, and presents a registered instruction/PC pair to decode with valid/stall flow control. Accepts a redirect (taken branch/jump target) from downstream and discards any wrong-path instruction in flight.

## Interface
- DWIDTH, 32, instruction width
- AWIDTH, 32, address width
- BASEADDR, 32'h0100_0000, reset PC (word aligned)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- imem_req_valid_o  out  1  request valid
- imem_req_addr_o  out  AWIDTH  request address
- imem_req_ready_i  in  1  memory accepts request this cycle
- imem_rsp_valid_i  in  1  response valid (always accepted, no back-pressure)
- imem_rsp_data_i  in  DWIDTH  response instruction
- redirect_i  in  1  taken branch/jump, flush and restart
- redirect_pc_i  in  AWIDTH  redirect target
- stall_i  in  1  decode cannot accept this cycle
- valid_o  out  1  insn_o/pc_o valid
- insn_o  out  DWIDTH  instruction to decode
- pc_o  out  AWIDTH  PC of insn_o

## Operation
- Registers: pc_q (next fetch addr), inflight_pc, kill flag, output buffer (valid_o/insn_o/pc_o), pending buffer (pend_insn, pend_pc).
- States: REQ, WAIT, HOLD.
- REQ: imem_req_valid_o=1, imem_req_addr_o=pc_q. On imem_req_ready_i: inflight_pc<=pc_q, pc_q<=pc_q+4, -> WAIT.
- WAIT: imem_req_valid_o=0. On imem_rsp_valid_i:
  - kill=1: drop response, kill<=0, -> REQ.
  - buffer free (valid_o=0, or valid_o&&!stall_i): load buffer with rsp data/inflight_pc, valid_o<=1, -> REQ.
  - buffer full and stall_i: store in pending buffer, -> HOLD.
- HOLD: imem_req_valid_o=0. When !stall_i: pending moves into output buffer (valid_o stays 1), -> REQ.
- Output consumed when valid_o && !stall_i; if nothing new loads, valid_o<=0.
- Redirect (highest priority, overrides all above in that cycle):
  - pc_q <= {redirect_pc_i[AWIDTH-1:2], 2'b00}; valid_o<=0; pending discarded.
  - REQ without acceptance, or REQ with acceptance: the redirect wins; no inflight request is recorded if not accepted -> REQ; if accepted the same cycle -> WAIT with kill<=1.
  - WAIT without response: kill<=1, stay WAIT. WAIT with response same cycle: response dropped, -> REQ.
  - HOLD: -> REQ.
- PC arithmetic: pc_q+4 modulo 2^AWIDTH (wraps from all-ones-minus-3 to 0).
- Request address must stay stable while imem_req_valid_o && !imem_req_ready_i, except in a redirect cycle (address changes the next cycle).
- Response with no request outstanding (REQ/HOLD) is ignored.

## Timing
- Reset (reset=0, async): state=REQ, pc_q=BASEADDR, kill=0, valid_o=0, insn_o=32'h0000_0013 (NOP), pc_o=BASEADDR, imem_req_valid_o=0 while reset asserted; imem_req_valid_o rises combinationally with state REQ in the first cycle after deassertion.
- Latency: request accepted cycle N, response N+k (k>=1), valid_o high from edge ending N+k.
- Peak throughput: 1 instruction per 2 cycles (REQ then WAIT with k=1).
- Redirect in cycle N: valid_o low from N+1; request to target in cycle N+1 (or after killed response drains).
- Reset mid-operation clears everything; any late response after reset is ignored (state REQ).

## Test plan
- Reset release, ready=1, k=1 memory returning addr-derived data -> requests 0x0100_0000, 0x0100_0004, ...; valid_o pulses every 2 cycles with matching pc_o/insn_o.
- stall_i held high 6 cycles after first insn -> second response goes to HOLD, no new request issued; on release insn 0x0100_0000 consumed then 0x0100_0004 shown next cycle, no loss or duplication.
- redirect_i with redirect_pc_i=0x0100_0203 while in WAIT, response 3 cycles later -> response dropped, next request addr 0x0100_0200, valid_o low until it returns.
- redirect_i in same cycle as imem_rsp_valid_i and as imem_req_ready_i (separate runs) -> wrong-path data never reaches valid_o; first post-redirect valid_o has pc_o = target.
- BASEADDR=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset for 1 cycle while in WAIT -> valid_o=0, pc_o=BASEADDR, insn_o=0x13 immediately; late response ignored; fetch restarts at BASEADDR.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, keeps one request outstanding to instruction memory,
// and hands a registered instruction/PC pair to decode, flushing wrong-path fetches on redirect.
module fetch_unit #(
   parameter int                DWIDTH   = 32,
   parameter int                AWIDTH   = 32,
   parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid_o,
   output logic [AWIDTH-1:0] imem_req_addr_o,
   input  logic              imem_req_ready_i,
   input  logic              imem_rsp_valid_i,
   input  logic [DWIDTH-1:0] imem_rsp_data_i,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] redirect_pc_i,
   input  logic              stall_i,
   output logic              valid_o,
   output logic [DWIDTH-1:0] insn_o,
   output logic [AWIDTH-1:0] pc_o
);

   localparam logic [DWIDTH-1:0] NOP_INSN = DWIDTH'(32'h0000_0013);
   localparam logic [AWIDTH-1:0] PC_STEP  = AWIDTH'(32'd4);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [AWIDTH-1:0]   pc_r, pc_s;
   logic [AWIDTH-1:0]   inflight_pc_r, inflight_pc_s;
   logic                kill_r, kill_s;
   logic                valid_r, valid_s;
   logic [DWIDTH-1:0]   insn_r, insn_s;
   logic [AWIDTH-1:0]   pc_out_r, pc_out_s;
   logic [DWIDTH-1:0]   pend_insn_r, pend_insn_s;
   logic [AWIDTH-1:0]   pend_pc_r, pend_pc_s;
   logic                unused_s;

   // Redirect targets are forced to word alignment, so the low bits are never used.
   assign unused_s = ^redirect_pc_i[1:0];

   assign imem_req_valid_o = (state_r == ST_REQ) && reset;
   assign imem_req_addr_o  = pc_r;
   assign valid_o          = valid_r;
   assign insn_o           = insn_r;
   assign pc_o             = pc_out_r;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_REQ;
         pc_r          <= BASEADDR;
         inflight_pc_r <= BASEADDR;
         kill_r        <= 1'b0;
         valid_r       <= 1'b0;
         insn_r        <= NOP_INSN;
         pc_out_r      <= BASEADDR;
         pend_insn_r   <= '0;
         pend_pc_r     <= '0;
      end else begin
         state_r       <= state_s;
         pc_r          <= pc_s;
         inflight_pc_r <= inflight_pc_s;
         kill_r        <= kill_s;
         valid_r       <= valid_s;
         insn_r        <= insn_s;
         pc_out_r      <= pc_out_s;
         pend_insn_r   <= pend_insn_s;
         pend_pc_r     <= pend_pc_s;
      end
   end

   // Next-state logic: redirect overrides the normal fetch/handoff flow.
   always_comb begin
      state_s       = state_r;
      pc_s          = pc_r;
      inflight_pc_s = inflight_pc_r;
      kill_s        = kill_r;
      insn_s        = insn_r;
      pc_out_s      = pc_out_r;
      pend_insn_s   = pend_insn_r;
      pend_pc_s     = pend_pc_r;
      if (valid_r && !stall_i) begin
         valid_s = 1'b0;
      end else begin
         valid_s = valid_r;
      end

      if (redirect_i) begin
         pc_s    = {redirect_pc_i[AWIDTH-1:2], 2'b00};
         valid_s = 1'b0;
         case (state_r)
            ST_REQ: begin
               // A request accepted in the redirect cycle is already wrong-path.
               if (imem_req_ready_i) begin
                  state_s = ST_WAIT;
                  kill_s  = 1'b1;
               end else begin
                  state_s = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid_i) begin
                  state_s = ST_REQ;
                  kill_s  = 1'b0;
               end else begin
                  state_s = ST_WAIT;
                  kill_s  = 1'b1;
               end
            end
            ST_HOLD: state_s = ST_REQ;
            default: state_s = ST_REQ;
         endcase
      end else begin
         case (state_r)
            ST_REQ: begin
               if (imem_req_ready_i) begin
                  inflight_pc_s = pc_r;
                  pc_s          = pc_r + PC_STEP;
                  state_s       = ST_WAIT;
               end else begin
                  state_s = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (!imem_rsp_valid_i) begin
                  state_s = ST_WAIT;
               end else if (kill_r) begin
                  kill_s  = 1'b0;
                  state_s = ST_REQ;
               end else if (!valid_r || !stall_i) begin
                  valid_s  = 1'b1;
                  insn_s   = imem_rsp_data_i;
                  pc_out_s = inflight_pc_r;
                  state_s  = ST_REQ;
               end else begin
                  pend_insn_s = imem_rsp_data_i;
                  pend_pc_s   = inflight_pc_r;
                  state_s     = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!stall_i) begin
                  valid_s  = 1'b1;
                  insn_s   = pend_insn_r;
                  pc_out_s = pend_pc_r;
                  state_s  = ST_REQ;
               end else begin
                  state_s = ST_HOLD;
               end
            end
            default: state_s = ST_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level model (expected fetch PC, in-flight flag,
// queue of delivered-but-unconsumed instructions) is compared against the DUT every cycle.
module tb_fetch_unit;

   localparam logic [31:0] BASE = 32'h0100_0000;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        valid;
   logic [31:0] insn;
   logic [31:0] pc;

   always #5 clk = ~clk;

   fetch_unit #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_req_valid_o (req_valid),
      .imem_req_addr_o  (req_addr),
      .imem_req_ready_i (req_ready),
      .imem_rsp_valid_i (rsp_valid),
      .imem_rsp_data_i  (rsp_data),
      .redirect_i       (redirect),
      .redirect_pc_i    (redirect_pc),
      .stall_i          (stall),
      .valid_o          (valid),
      .insn_o           (insn),
      .pc_o             (pc)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // reference model
   logic [31:0] m_pc = BASE;
   logic [31:0] m_inpc = BASE;
   bit          m_out = 1'b0;
   bit          m_kill = 1'b0;
   logic [31:0] q_pc[$];
   logic [31:0] q_insn[$];

   // memory environment
   bit          mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] acc_log[$];

   // stimulus knobs
   int          p_rdy = 100, p_stall = 0, p_redir = 0, p_spur = 0;
   int          k_fix = 1, k_max = 1, force_stall = -1, redir_mode = 0;
   logic [31:0] redir_target = 32'h0;

   task automatic step(input bit rst_val);
      bit exp_req, fired;
      @(negedge clk);
      reset = rst_val;
      #1;
      if (!reset) begin
         m_pc = BASE; m_out = 1'b0; m_kill = 1'b0;
         q_pc.delete(); q_insn.delete();
         check("rst_valid", {31'd0, valid}, 32'd0);
         check("rst_pc", pc, BASE);
         check("rst_insn", insn, NOP);
         check("rst_req_valid", {31'd0, req_valid}, 32'd0);
      end else begin
         exp_req = !m_out && (q_pc.size() < 2);
         check("valid", {31'd0, valid}, {31'd0, q_pc.size() > 0});
         if (q_pc.size() > 0) begin
            check("pc_o", pc, q_pc[0]);
            check("insn_o", insn, q_insn[0]);
         end
         check("req_valid", {31'd0, req_valid}, {31'd0, exp_req});
         if (exp_req) check("req_addr", req_addr, m_pc);
      end
      exp_req = !m_out && (q_pc.size() < 2);

      req_ready = !mem_busy && ($urandom_range(99) < p_rdy);
      if (mem_busy) begin
         rsp_valid = (mem_cnt == 0);
         rsp_data  = rsp_valid ? mem_word(mem_addr) : $urandom;
      end else begin
         rsp_valid = ($urandom_range(99) < p_spur);
         rsp_data  = $urandom;
      end
      stall       = (force_stall >= 0) ? (force_stall != 0) : ($urandom_range(99) < p_stall);
      redirect    = 1'b0;
      redirect_pc = $urandom;
      fired       = 1'b0;
      case (redir_mode)
         0: redirect = ($urandom_range(99) < p_redir);
         1: fired = mem_busy && m_out && !rsp_valid;
         2: fired = mem_busy && m_out && !m_kill && rsp_valid;
         3: fired = exp_req && req_ready;
         4: fired = 1'b1;
         default: fired = 1'b0;
      endcase
      if (fired) begin
         redirect    = 1'b1;
         redirect_pc = redir_target;
      end
      #1;

      if (reset) begin
         if (q_pc.size() > 0 && !stall) begin
            void'(q_pc.pop_front());
            void'(q_insn.pop_front());
         end
         if (redirect) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            q_pc.delete(); q_insn.delete();
            if (exp_req && req_ready) begin
               m_out = 1'b1; m_kill = 1'b1;
            end else if (m_out && rsp_valid) begin
               m_out = 1'b0; m_kill = 1'b0;
            end else if (m_out) begin
               m_kill = 1'b1;
            end
         end else if (exp_req && req_ready) begin
            m_out = 1'b1; m_kill = 1'b0; m_inpc = m_pc; m_pc = m_pc + 32'd4;
         end else if (m_out && rsp_valid) begin
            m_out = 1'b0;
            if (m_kill) m_kill = 1'b0;
            else begin
               q_pc.push_back(m_inpc);
               q_insn.push_back(mem_word(m_inpc));
            end
         end
      end

      if (mem_busy) begin
         if (mem_cnt == 0) mem_busy = 1'b0;
         else mem_cnt--;
      end else if (req_valid && req_ready) begin
         mem_busy = 1'b1;
         mem_addr = req_addr;
         mem_cnt  = (k_fix > 0) ? k_fix - 1 : $urandom_range(k_max - 1);
         acc_log.push_back(req_addr);
      end
      if (fired) begin
         redir_mode = 0;
         if (redirect_pc == 32'hFFFF_FFF8) acc_log.delete();
      end
   endtask

   initial begin
      bit found;
      reset = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
      redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;

      repeat (3) step(1'b0);
      repeat (20) step(1'b1);

      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1);
         found = valid;
      end
      check("stall_wait_valid", {31'd0, valid}, 32'd1);
      force_stall = 1;
      repeat (6) step(1'b1);
      force_stall = 0;
      repeat (6) step(1'b1);
      force_stall = -1;

      k_fix = 3; redir_target = 32'h0100_0203; redir_mode = 1;
      repeat (14) step(1'b1);
      check("redir_wait_fired", redir_mode, 32'd0);

      k_fix = 1; redir_target = 32'h0100_0400; redir_mode = 2;
      repeat (10) step(1'b1);
      check("redir_rsp_fired", redir_mode, 32'd0);

      redir_target = 32'h0100_0800; redir_mode = 3;
      repeat (10) step(1'b1);
      check("redir_acc_fired", redir_mode, 32'd0);

      redir_target = 32'hFFFF_FFF8; redir_mode = 4;
      repeat (10) step(1'b1);
      check("wrap_a0", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
      check("wrap_a1", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      check("wrap_a2", (acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);

      k_fix = 4;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1'b1);
         found = m_out && mem_busy && (mem_cnt >= 2);
      end
      check("rst_mid_wait_found", {31'd0, found}, 32'd1);
      acc_log.delete();
      step(1'b0);
      repeat (14) step(1'b1);
      check("rst_restart_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, BASE);

      k_fix = 0; k_max = 4; p_rdy = 60; p_stall = 30; p_redir = 4; p_spur = 10;
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(499) == 0) ? 1'b0 : 1'b1);
      end

      p_rdy = 0; p_redir = 0; p_stall = 0;
      repeat (20) step(1'b1);
      check("drain_valid", {31'd0, valid}, 32'd0);
      check("drain_queue", q_pc.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
